// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard/stall controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        DRAIN    = 2'd2,
        HALTED   = 2'd3
    } hazardState_t;

    localparam int         DEF_REG_W   = 4;
    localparam int         DEF_OP_W    = 3;
    localparam logic [2:0] DEF_OP_LW   = 3'b101;
    localparam logic [2:0] DEF_OP_XORI = 3'b001;
    localparam logic [2:0] DEF_OP_END  = 3'b111;

    function automatic int maxInt(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational decode of load-use hazards and the END opcode from ID/EX fields.
module hazard_detect
    import hazard_pkg::*;
#(
    parameter int             REG_W          = DEF_REG_W,
    parameter int             OP_W           = DEF_OP_W,
    parameter logic [OP_W-1:0] OP_LW         = DEF_OP_LW,
    parameter logic [OP_W-1:0] OP_XORI       = DEF_OP_XORI,
    parameter logic [OP_W-1:0] OP_END        = DEF_OP_END,
    parameter int             ZERO_REG_CONST = 1
) (
    input  logic             idValid,
    input  logic [OP_W-1:0]  idOp,
    input  logic [REG_W-1:0] idRs,
    input  logic [REG_W-1:0] idRt,
    input  logic             exMemRead,
    input  logic [REG_W-1:0] exRt,
    output logic             lu,
    output logic             isEnd
);

    logic destLive;
    logic rtIsSource;

    // Loads and immediates write rt, so only other opcodes read it as a source.
    assign destLive   = (exRt != '0) || (ZERO_REG_CONST == 0);
    assign rtIsSource = (idOp != OP_LW) && (idOp != OP_XORI);

    assign lu    = idValid && exMemRead && destLive &&
                   ((exRt == idRs) || ((exRt == idRt) && rtIsSource));
    assign isEnd = idValid && (idOp == OP_END);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller: load-use stalls, branch flushes, END drain and sticky halt.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int              REG_W          = DEF_REG_W,
    parameter int              OP_W           = DEF_OP_W,
    parameter logic [OP_W-1:0] OP_LW          = DEF_OP_LW,
    parameter logic [OP_W-1:0] OP_XORI        = DEF_OP_XORI,
    parameter logic [OP_W-1:0] OP_END         = DEF_OP_END,
    parameter int              LOAD_STALL     = 1,
    parameter int              DRAIN_CYCLES   = 3,
    parameter int              ZERO_REG_CONST = 1,
    parameter int              PERF_W         = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [OP_W-1:0]   id_op,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic              ex_mem_read,
    input  logic [REG_W-1:0]  ex_rt,
    input  logic              ex_branch_taken,
    output logic              pc_write_en,
    output logic              ifid_write_en,
    output logic              ifid_flush,
    output logic              stall_flush,
    output logic              halted,
    output logic [PERF_W-1:0] stall_cycles
);

    localparam int CNT_W = $clog2(maxInt(LOAD_STALL, DRAIN_CYCLES) + 1);

    hazardState_t      stateReg, stateNext;
    logic [CNT_W-1:0]  cntReg, cntNext;
    logic              haltedReg;
    logic [PERF_W-1:0] stallCyclesReg;
    logic              lu, isEnd;

    hazard_detect #(
        .REG_W          (REG_W),
        .OP_W           (OP_W),
        .OP_LW          (OP_LW),
        .OP_XORI        (OP_XORI),
        .OP_END         (OP_END),
        .ZERO_REG_CONST (ZERO_REG_CONST)
    ) uDetect (
        .idValid   (id_valid),
        .idOp      (id_op),
        .idRs      (id_rs),
        .idRt      (id_rt),
        .exMemRead (ex_mem_read),
        .exRt      (ex_rt),
        .lu        (lu),
        .isEnd     (isEnd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg       <= RUN;
            cntReg         <= '0;
            haltedReg      <= 1'b0;
            stallCyclesReg <= '0;
        end else begin
            stateReg  <= stateNext;
            cntReg    <= cntNext;
            haltedReg <= (stateNext == HALTED);
            if (stall_flush && (stallCyclesReg != '1))
                stallCyclesReg <= stallCyclesReg + PERF_W'(1);
        end
    end

    // The detection cycle is the first stall cycle, so the counter loads length-1.
    always_comb begin
        stateNext = stateReg;
        cntNext   = cntReg;
        case (stateReg)
            RUN: begin
                if (ex_branch_taken) begin
                    stateNext = RUN;
                end else if (isEnd) begin
                    if (DRAIN_CYCLES == 1) begin
                        stateNext = HALTED;
                    end else begin
                        stateNext = DRAIN;
                        cntNext   = CNT_W'(DRAIN_CYCLES - 1);
                    end
                end else if (lu && (LOAD_STALL > 1)) begin
                    stateNext = LU_STALL;
                    cntNext   = CNT_W'(LOAD_STALL - 1);
                end
            end
            LU_STALL, DRAIN: begin
                if (ex_branch_taken) begin
                    stateNext = RUN;
                    cntNext   = '0;
                end else begin
                    cntNext = cntReg - CNT_W'(1);
                    if (cntReg == CNT_W'(1))
                        stateNext = (stateReg == DRAIN) ? HALTED : RUN;
                end
            end
            default: begin
                stateNext = HALTED;
            end
        endcase
    end

    always_comb begin
        pc_write_en   = 1'b1;
        ifid_write_en = 1'b1;
        ifid_flush    = 1'b0;
        stall_flush   = 1'b0;
        case (stateReg)
            RUN: begin
                if (ex_branch_taken) begin
                    ifid_flush  = 1'b1;
                    stall_flush = 1'b1;
                end else if (isEnd || lu) begin
                    pc_write_en   = 1'b0;
                    ifid_write_en = 1'b0;
                    stall_flush   = 1'b1;
                end
            end
            LU_STALL, DRAIN: begin
                if (ex_branch_taken) begin
                    ifid_flush  = 1'b1;
                    stall_flush = 1'b1;
                end else begin
                    pc_write_en   = 1'b0;
                    ifid_write_en = 1'b0;
                    stall_flush   = 1'b1;
                end
            end
            default: begin
                pc_write_en   = 1'b0;
                ifid_write_en = 1'b0;
                stall_flush   = 1'b1;
            end
        endcase
    end

    assign halted       = haltedReg;
    assign stall_cycles = stallCyclesReg;

endmodule
